mem_access_stage: RTL and testbench

Memory-access stage directly downstream of the ALU in the Harvard 5-instruction core (ADDU, ADDIU, LW, SW, JR). It accepts one executed instruction at a time, carrying the ALU result, store data and destination register. It performs LW/SW through a waitrequest-style data-memory port and passes non-memory results straight through. It emits one writeback-ready result per accepted instruction and back-pressures the execute stage while a memory transfer is outstanding.

---
 rtl/mem_access_stage.sv | 132 +++++++++++++
 tb/tb_mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: performs LW/SW over a waitrequest data-memory port and
// passes ALU results through, emitting one writeback result or error per instruction.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [5:0]  in_func,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_error
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam bit             TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state;
  logic [4:0]       rd_p0;
  logic [CNT_W-1:0] wait_cnt;

  logic is_lw, is_sw, is_pass, is_jr, misaligned, timeout_hit;

  assign is_lw       = (in_opcode == OP_LW);
  assign is_sw       = (in_opcode == OP_SW);
  assign is_pass     = (in_opcode == OP_ADDIU) ||
                       ((in_opcode == OP_RTYPE) && (in_func == FN_ADDU));
  assign is_jr       = (in_opcode == OP_RTYPE) && (in_func == FN_JR);
  assign misaligned  = (in_alu_out[1:0] != 2'b00);
  // The abort fires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

  assign in_ready  = (state == IDLE);
  assign mem_read  = (state == READ);
  assign mem_write = (state == WRITE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rd_p0         <= '0;
      wait_cnt      <= '0;
      mem_address   <= '0;
      mem_writedata <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_error     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_error <= 1'b0;
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (in_valid) begin
            if (is_lw || is_sw) begin
              if (misaligned) begin
                out_error <= 1'b1;
              end else begin
                mem_address   <= in_alu_out;
                mem_writedata <= in_store_data;
                rd_p0         <= in_rd;
                state         <= is_lw ? READ : WRITE;
              end
            end else if (is_pass) begin
              out_valid     <= 1'b1;
              out_data      <= in_alu_out;
              out_rd        <= in_rd;
              out_reg_write <= 1'b1;
            end else if (is_jr) begin
              out_valid     <= 1'b1;
              out_reg_write <= 1'b0;
            end else begin
              out_error <= 1'b1;
            end
          end
        end
        READ: begin
          if (!mem_waitrequest) begin
            out_valid     <= 1'b1;
            out_data      <= mem_readdata;
            out_rd        <= rd_p0;
            out_reg_write <= 1'b1;
            state         <= IDLE;
          end else if (timeout_hit) begin
            out_error <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (!mem_waitrequest) begin
            out_valid     <= 1'b1;
            out_reg_write <= 1'b0;
            state         <= IDLE;
          end else if (timeout_hit) begin
            out_error <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized back-to-back
// traffic checked against a transaction-level model (TIMEOUT_CYCLES=4).
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_func;
  logic [31:0] in_alu_out;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_error;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_func(in_func),
    .in_alu_out(in_alu_out), .in_store_data(in_store_data), .in_rd(in_rd),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_error(out_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Writeback outputs as the model expects them to be held.
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  logic        m_rw;

  typedef struct {
    int req_cycles; int lat;
    bit got_valid; bit got_error; bit both_pulse;
    bit addr_bad; bit data_bad; bit ready_in_req; bit both_req;
    bit ready_at_start; bit hung;
  } obs_t;

  typedef struct {
    int req_cycles; int lat; bit valid; bit error;
    logic [31:0] data; logic [4:0] rd; logic rw;
  } exp_t;

  // One instruction's outcome from the behavioural rules: waits = stalled cycles.
  function automatic exp_t predict(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [31:0] alu, input logic [31:0] rdata,
                                   input logic [4:0] rd, input int waits);
    exp_t e;
    e.data = m_data; e.rd = m_rd; e.rw = m_rw;
    e.valid = 1'b0; e.error = 1'b0; e.req_cycles = 0; e.lat = 1;
    if (op == 6'h23 || op == 6'h2b) begin
      if (alu[1:0] != 2'b00) e.error = 1'b1;
      else if (waits >= TO) begin
        e.req_cycles = TO; e.lat = TO + 1; e.error = 1'b1;
      end else begin
        e.req_cycles = waits + 1; e.lat = waits + 2; e.valid = 1'b1;
        if (op == 6'h23) begin e.data = rdata; e.rd = rd; e.rw = 1'b1; end
        else e.rw = 1'b0;
      end
    end else if (op == 6'h09 || (op == 6'h00 && fn == 6'h21)) begin
      e.valid = 1'b1; e.data = alu; e.rd = rd; e.rw = 1'b1;
    end else if (op == 6'h00 && fn == 6'h08) begin
      e.valid = 1'b1; e.rw = 1'b0;
    end else begin
      e.error = 1'b1;
    end
    return e;
  endfunction

  // Drives one instruction starting at the current negedge and acts as the memory;
  // returns at the negedge where out_valid or out_error is seen.
  task automatic run_txn(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input int waits, output obs_t o);
    int k;
    o = '{default: 0};
    o.ready_at_start = in_ready;
    in_valid = 1'b1; in_opcode = op; in_func = fn; in_alu_out = alu;
    in_store_data = sd; in_rd = rd; mem_waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_alu_out = $urandom; in_store_data = $urandom;
    k = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (mem_read && mem_write) o.both_req = 1'b1;
      if (mem_read || mem_write) begin
        k++;
        o.req_cycles = k;
        if (mem_address !== alu) o.addr_bad = 1'b1;
        if (mem_write && mem_writedata !== sd) o.data_bad = 1'b1;
        if (in_ready) o.ready_in_req = 1'b1;
        mem_waitrequest = (k <= waits);
        mem_readdata = (k <= waits) ? $urandom : rdata;
      end
      if (out_valid || out_error) begin
        o.lat = cyc; o.got_valid = out_valid; o.got_error = out_error;
        o.both_pulse = out_valid && out_error;
        mem_waitrequest = 1'b0;
        return;
      end
      @(negedge clk);
    end
    o.hung = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_func = '0;
    in_alu_out = '0; in_store_data = '0; in_rd = '0;
    mem_readdata = '0; mem_waitrequest = 1'b0;
    m_data = '0; m_rd = '0; m_rw = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_mem_req got %b exp 00", {mem_read, mem_write}); end
    checks++; if ({out_valid, out_error, out_reg_write} !== 3'b000) begin errors++; $display("FAIL reset_out_flags got %b exp 000", {out_valid, out_error, out_reg_write}); end
    checks++; if (out_data !== 32'h0 || out_rd !== 5'h0) begin errors++; $display("FAIL reset_out_data got %h/%0d exp 0/0", out_data, out_rd); end
    checks++; if (mem_address !== 32'h0 || mem_writedata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus got %h/%h exp 0/0", mem_address, mem_writedata); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_addiu();
    obs_t o;
    run_txn(6'h09, 6'h00, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 0, o);
    checks++; if (o.lat !== 1 || o.got_valid !== 1'b1 || o.got_error !== 1'b0) begin errors++; $display("FAIL addiu_pulse got lat %0d v %b e %b exp 1 1 0", o.lat, o.got_valid, o.got_error); end
    checks++; if (out_data !== 32'h1234 || out_rd !== 5'd5 || out_reg_write !== 1'b1) begin errors++; $display("FAIL addiu_result got %h/%0d/%b exp 1234/5/1", out_data, out_rd, out_reg_write); end
    checks++; if (o.req_cycles !== 0) begin errors++; $display("FAIL addiu_no_mem got %0d exp 0", o.req_cycles); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL addiu_single_pulse got v %b r %b w %b exp 000", out_valid, mem_read, mem_write); end
    m_data = 32'h1234; m_rd = 5'd5; m_rw = 1'b1;
  endtask

  task automatic test_lw_zero_wait();
    obs_t o;
    run_txn(6'h23, 6'h00, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd7, 0, o);
    checks++; if (o.req_cycles !== 1 || o.addr_bad !== 1'b0) begin errors++; $display("FAIL lw0_request got %0d cycles addr_bad %b exp 1 0", o.req_cycles, o.addr_bad); end
    checks++; if (o.lat !== 2 || o.got_valid !== 1'b1) begin errors++; $display("FAIL lw0_latency got %0d v %b exp 2 1", o.lat, o.got_valid); end
    checks++; if (out_data !== 32'hDEAD_BEEF || out_rd !== 5'd7 || out_reg_write !== 1'b1) begin errors++; $display("FAIL lw0_result got %h/%0d/%b exp deadbeef/7/1", out_data, out_rd, out_reg_write); end
    m_data = 32'hDEAD_BEEF; m_rd = 5'd7; m_rw = 1'b1;
  endtask

  task automatic test_sw_waits();
    obs_t o;
    run_txn(6'h2b, 6'h00, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 5'd9, 3, o);
    checks++; if (o.req_cycles !== 4) begin errors++; $display("FAIL sw3_hold got %0d exp 4", o.req_cycles); end
    checks++; if (o.addr_bad !== 1'b0 || o.data_bad !== 1'b0) begin errors++; $display("FAIL sw3_stable got addr %b data %b exp 0 0", o.addr_bad, o.data_bad); end
    checks++; if (o.ready_in_req !== 1'b0) begin errors++; $display("FAIL sw3_backpressure got %b exp 0", o.ready_in_req); end
    checks++; if (o.lat !== 5 || o.got_valid !== 1'b1 || out_reg_write !== 1'b0) begin errors++; $display("FAIL sw3_done got lat %0d v %b rw %b exp 5 1 0", o.lat, o.got_valid, out_reg_write); end
    m_rw = 1'b0;
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_txn(6'h23, 6'h00, 32'h0000_0102, 32'h0, 32'h1111_2222, 5'd4, 0, o);
    checks++; if (o.req_cycles !== 0) begin errors++; $display("FAIL mis_no_read got %0d exp 0", o.req_cycles); end
    checks++; if (o.lat !== 1 || o.got_error !== 1'b1 || o.got_valid !== 1'b0) begin errors++; $display("FAIL mis_error got lat %0d e %b v %b exp 1 1 0", o.lat, o.got_error, o.got_valid); end
    checks++; if (out_data !== m_data || out_rd !== m_rd) begin errors++; $display("FAIL mis_hold got %h/%0d exp %h/%0d", out_data, out_rd, m_data, m_rd); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(6'h23, 6'h00, 32'h0000_0800, 32'h0, 32'h0, 5'd2, 1000, o);
    checks++; if (o.req_cycles !== TO) begin errors++; $display("FAIL to_drop got %0d exp %0d", o.req_cycles, TO); end
    checks++; if (o.got_error !== 1'b1 || o.got_valid !== 1'b0 || o.lat !== TO + 1) begin errors++; $display("FAIL to_error got e %b v %b lat %0d exp 1 0 %0d", o.got_error, o.got_valid, o.lat, TO + 1); end
    run_txn(6'h00, 6'h21, 32'h0000_0055, 32'h0, 32'h0, 5'd3, 0, o);
    checks++; if (o.ready_at_start !== 1'b1 || o.got_valid !== 1'b1 || o.lat !== 1) begin errors++; $display("FAIL to_next_addu got rdy %b v %b lat %0d exp 1 1 1", o.ready_at_start, o.got_valid, o.lat); end
    checks++; if (out_data !== 32'h55 || out_rd !== 5'd3 || out_reg_write !== 1'b1) begin errors++; $display("FAIL to_next_result got %h/%0d/%b exp 55/3/1", out_data, out_rd, out_reg_write); end
    m_data = 32'h55; m_rd = 5'd3; m_rw = 1'b1;
  endtask

  task automatic test_random_back_to_back();
    obs_t o; exp_t e;
    logic [5:0] op, fn; logic [31:0] alu, sd, rdata; logic [4:0] rd;
    int pick, waits;
    for (int t = 0; t < 60; t++) begin
      pick = int'($urandom_range(0, 9));
      fn = 6'($urandom); alu = $urandom; sd = $urandom; rdata = $urandom; rd = 5'($urandom);
      waits = int'($urandom_range(0, 5));
      case (pick)
        0, 1, 2: op = 6'h23;
        3, 4:    op = 6'h2b;
        5:       begin op = 6'h00; fn = 6'h21; end
        6:       op = 6'h09;
        7:       begin op = 6'h00; fn = 6'h08; end
        8:       begin op = 6'h00; if (fn == 6'h21 || fn == 6'h08) fn = 6'h20; end
        default: begin
          op = 6'($urandom);
          if (op == 6'h00 || op == 6'h09 || op == 6'h23 || op == 6'h2b) op = 6'h3f;
        end
      endcase
      if ((op == 6'h23 || op == 6'h2b) && $urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      e = predict(op, fn, alu, rdata, rd, waits);
      run_txn(op, fn, alu, sd, rdata, rd, waits, o);
      checks++; if (o.hung !== 1'b0 || o.lat !== e.lat) begin errors++; $display("FAIL rand_latency txn %0d op %h got %0d exp %0d", t, op, o.lat, e.lat); end
      checks++; if (o.req_cycles !== e.req_cycles) begin errors++; $display("FAIL rand_req_cycles txn %0d op %h got %0d exp %0d", t, op, o.req_cycles, e.req_cycles); end
      checks++; if (o.got_valid !== e.valid || o.got_error !== e.error) begin errors++; $display("FAIL rand_pulse txn %0d op %h got v %b e %b exp v %b e %b", t, op, o.got_valid, o.got_error, e.valid, e.error); end
      checks++; if (out_data !== e.data || out_rd !== e.rd || out_reg_write !== e.rw) begin errors++; $display("FAIL rand_result txn %0d op %h got %h/%0d/%b exp %h/%0d/%b", t, op, out_data, out_rd, out_reg_write, e.data, e.rd, e.rw); end
      checks++; if ({o.addr_bad, o.data_bad, o.ready_in_req, o.both_req, o.both_pulse, ~o.ready_at_start} !== 6'b0) begin errors++; $display("FAIL rand_protocol txn %0d got %b exp 000000", t, {o.addr_bad, o.data_bad, o.ready_in_req, o.both_req, o.both_pulse, ~o.ready_at_start}); end
      m_data = e.data; m_rd = e.rd; m_rw = e.rw;
      if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_read();
    obs_t o;
    bit bad;
    in_valid = 1'b1; in_opcode = 6'h23; in_func = 6'h00; in_alu_out = 32'h0000_0400;
    in_rd = 5'd12; mem_waitrequest = 1'b1; mem_readdata = 32'h9999_8888;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_read !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_pre got r %b rdy %b exp 1 0", mem_read, in_ready); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_drop got r %b rdy %b exp 0 1", mem_read, in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || out_error || mem_read || mem_write) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet got activity %b exp 0", bad); end
    checks++; if (out_data !== 32'h0 || out_reg_write !== 1'b0) begin errors++; $display("FAIL rst_mid_cleared got %h/%b exp 0/0", out_data, out_reg_write); end
    run_txn(6'h00, 6'h21, 32'hA5A5_0001, 32'h0, 32'h0, 5'd30, 0, o);
    checks++; if (o.got_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || out_rd !== 5'd30) begin errors++; $display("FAIL rst_mid_resume got v %b %h/%0d exp 1 a5a50001/30", o.got_valid, out_data, out_rd); end
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_lw_zero_wait();
    test_sw_waits();
    test_misaligned();
    test_timeout();
    test_random_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
